// File: rtl/uart_rx_deser_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deser_param
// Purpose  : UART receive-path deserializer. Assembles DATA_WIDTH sampled
//            bits (LSB- or MSB-first), counts bits internally, computes the
//            expected parity bit and presents the finished word through a
//            valid/ready output register. A word that completes while the
//            previous one is still unconsumed is dropped and flagged with a
//            one-cycle overrun pulse.
// Ports    : clk          - clock
//            rst          - synchronous, active-low reset
//            sampled_bit  - data bit from the sampler
//            deser_en     - strobe: accept sampled_bit as the next data bit
//            frame_start  - strobe: start bit detected, begin a new word
//            par_typ      - 0 = even parity, 1 = odd parity
//            out_data     - completed word
//            out_valid    - out_data/par_bit hold an unconsumed word
//            out_ready    - consumer accepts the word while out_valid is high
//            par_bit      - expected parity bit for out_data
//            overrun      - one-cycle pulse: a completed word was dropped
//            busy         - high while a word is being assembled
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deser_param #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sampled_bit,
    input  logic                  deser_en,
    input  logic                  frame_start,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  par_bit,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_shreg;

    logic [DATA_WIDTH-1:0] w_next_shreg;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_next_par;

    // Shift direction selects where the first received bit ends up.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_next_shreg = {sampled_bit, r_shreg[DATA_WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_next_shreg = {r_shreg[DATA_WIDTH-2:0], sampled_bit};
        end
    endgenerate

    // frame_start has priority: a coincident data bit is discarded.
    assign w_accept   = (r_state == ST_SHIFT) && deser_en && !frame_start;
    assign w_complete = w_accept && (r_cnt == c_last_bit);
    assign w_next_par = (^w_next_shreg) ^ par_typ;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shreg   <= '0;
            busy      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            par_bit   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;

            // Assembly state machine.
            if (frame_start) begin
                r_state <= ST_SHIFT;
                r_cnt   <= '0;
                r_shreg <= '0;
                busy    <= 1'b1;
            end else if (w_accept) begin
                r_shreg <= w_next_shreg;
                if (w_complete) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end

            // Output register: a completing word may replace a word that is
            // being handshaken in the same cycle; otherwise it is dropped.
            if (w_complete) begin
                if (!out_valid || out_ready) begin
                    out_data  <= w_next_shreg;
                    par_bit   <= w_next_par;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deser_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deser_param
// Purpose  : Directed self-checking bench for uart_rx_deser_param. Three
//            instances share the stimulus: W=8 LSB-first, W=8 MSB-first and
//            W=5 LSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deser_param;

    logic clk;
    logic rst;
    logic sampled_bit;
    logic deser_en;
    logic frame_start;
    logic par_typ;
    logic out_ready;

    logic [7:0] l8_data;
    logic       l8_valid, l8_par, l8_ovr, l8_busy;
    logic [7:0] m8_data;
    logic       m8_valid, m8_par, m8_ovr, m8_busy;
    logic [4:0] l5_data;
    logic       l5_valid, l5_par, l5_ovr, l5_busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_deser_param #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_l8 (
        .clk(clk), .rst(rst), .sampled_bit(sampled_bit), .deser_en(deser_en),
        .frame_start(frame_start), .par_typ(par_typ), .out_data(l8_data),
        .out_valid(l8_valid), .out_ready(out_ready), .par_bit(l8_par),
        .overrun(l8_ovr), .busy(l8_busy)
    );

    uart_rx_deser_param #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_m8 (
        .clk(clk), .rst(rst), .sampled_bit(sampled_bit), .deser_en(deser_en),
        .frame_start(frame_start), .par_typ(par_typ), .out_data(m8_data),
        .out_valid(m8_valid), .out_ready(out_ready), .par_bit(m8_par),
        .overrun(m8_ovr), .busy(m8_busy)
    );

    uart_rx_deser_param #(.DATA_WIDTH(5), .LSB_FIRST(1'b1)) u_l5 (
        .clk(clk), .rst(rst), .sampled_bit(sampled_bit), .deser_en(deser_en),
        .frame_start(frame_start), .par_typ(par_typ), .out_data(l5_data),
        .out_valid(l5_valid), .out_ready(out_ready), .par_bit(l5_par),
        .overrun(l5_ovr), .busy(l5_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // bits[i] is the i-th received bit. Optionally raise out_ready on the last bit only.
    task automatic send_bits(input logic [15:0] bits, input int n, input bit rdy_last);
        for (int i = 0; i < n; i++) begin
            sampled_bit = bits[i];
            deser_en    = 1'b1;
            if (rdy_last && i == n - 1) out_ready = 1'b1;
            tick();
        end
        deser_en = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] bits, input int n, input bit rdy_last);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        send_bits(bits, n, rdy_last);
    endtask

    initial begin
        rst         = 1'b1;
        sampled_bit = 1'b0;
        deser_en    = 1'b0;
        frame_start = 1'b0;
        par_typ     = 1'b0;
        out_ready   = 1'b0;

        // Reset state.
        do_reset();
        chk("rst_data",  {24'd0, l8_data}, 32'h0);
        chk("rst_valid", {31'd0, l8_valid}, 32'h0);
        chk("rst_par",   {31'd0, l8_par}, 32'h0);
        chk("rst_ovr",   {31'd0, l8_ovr}, 32'h0);
        chk("rst_busy",  {31'd0, l8_busy}, 32'h0);

        // busy follows frame_start by one edge.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("busy_rise", {31'd0, l8_busy}, 32'h1);

        // Basic frame 1,1,0,0,0,0,0,0 with out_ready high, even parity.
        do_reset();
        out_ready = 1'b1;
        par_typ   = 1'b0;
        send_frame(16'h0003, 8, 1'b0);
        chk("lsb_data",   {24'd0, l8_data}, 32'h03);
        chk("lsb_par",    {31'd0, l8_par}, 32'h0);
        chk("lsb_valid",  {31'd0, l8_valid}, 32'h1);
        chk("lsb_busy",   {31'd0, l8_busy}, 32'h0);
        chk("msb_data",   {24'd0, m8_data}, 32'hC0);
        tick();
        chk("valid_1cyc", {31'd0, l8_valid}, 32'h0);
        chk("keep_data",  {24'd0, l8_data}, 32'h03);

        // Same frame with odd parity.
        par_typ = 1'b1;
        send_frame(16'h0003, 8, 1'b0);
        chk("odd_par", {31'd0, l8_par}, 32'h1);
        par_typ = 1'b0;

        // W=5: bits 1,0,1,1,0.
        do_reset();
        send_frame(16'h000D, 5, 1'b0);
        chk("w5_data",  {27'd0, l5_data}, 32'h0D);
        chk("w5_par",   {31'd0, l5_par}, 32'h1);
        chk("w5_valid", {31'd0, l5_valid}, 32'h1);

        // Overrun: two frames with no consumer.
        do_reset();
        out_ready = 1'b0;
        send_frame(16'h0003, 8, 1'b0);
        chk("ovr_first_valid", {31'd0, l8_valid}, 32'h1);
        chk("ovr_none_yet",    {31'd0, l8_ovr}, 32'h0);
        send_frame(16'h00FF, 8, 1'b0);
        chk("ovr_pulse", {31'd0, l8_ovr}, 32'h1);
        chk("ovr_keep",  {24'd0, l8_data}, 32'h03);
        out_ready = 1'b1;
        tick();
        chk("ovr_once",   {31'd0, l8_ovr}, 32'h0);
        chk("ovr_drain",  {31'd0, l8_valid}, 32'h0);
        chk("ovr_data",   {24'd0, l8_data}, 32'h03);

        // Completion coinciding with a handshake of the previous word.
        do_reset();
        out_ready = 1'b0;
        send_frame(16'h0003, 8, 1'b0);
        send_frame(16'h00FF, 8, 1'b1);
        chk("swap_data",  {24'd0, l8_data}, 32'hFF);
        chk("swap_valid", {31'd0, l8_valid}, 32'h1);
        chk("swap_ovr",   {31'd0, l8_ovr}, 32'h0);
        chk("swap_par",   {31'd0, l8_par}, 32'h0);

        // Back-to-back frames with out_ready tied high.
        do_reset();
        out_ready = 1'b1;
        send_frame(16'h0003, 8, 1'b0);
        send_frame(16'h00A5, 8, 1'b0);
        chk("b2b_data", {24'd0, l8_data}, 32'hA5);
        chk("b2b_ovr",  {31'd0, l8_ovr}, 32'h0);

        // Restart: 3 bits, frame_start together with deser_en, then 8 bits.
        do_reset();
        send_frame(16'h0007, 3, 1'b0);
        frame_start = 1'b1;
        deser_en    = 1'b1;
        sampled_bit = 1'b1;
        tick();
        frame_start = 1'b0;
        deser_en    = 1'b0;
        chk("restart_novalid", {31'd0, l8_valid}, 32'h0);
        send_bits(16'h00F0, 8, 1'b0);
        chk("restart_lsb", {24'd0, l8_data}, 32'hF0);
        chk("restart_msb", {24'd0, m8_data}, 32'h0F);
        chk("restart_par", {31'd0, l8_par}, 32'h0);

        // Reset mid-frame with a pending word, then IDLE strobes, then a frame.
        do_reset();
        out_ready = 1'b0;
        send_frame(16'h0003, 8, 1'b0);
        send_frame(16'h000F, 4, 1'b0);
        chk("mid_busy", {31'd0, l8_busy}, 32'h1);
        do_reset();
        chk("mid_rst_data",  {24'd0, l8_data}, 32'h0);
        chk("mid_rst_valid", {31'd0, l8_valid}, 32'h0);
        chk("mid_rst_busy",  {31'd0, l8_busy}, 32'h0);
        sampled_bit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            deser_en = 1'b1;
            tick();
            deser_en = 1'b0;
            tick();
        end
        chk("idle_busy",  {31'd0, l8_busy}, 32'h0);
        chk("idle_valid", {31'd0, l8_valid}, 32'h0);
        chk("idle_data",  {24'd0, l8_data}, 32'h0);
        par_typ = 1'b1;
        send_frame(16'h0035, 8, 1'b0);
        chk("post_lsb", {24'd0, l8_data}, 32'h35);
        chk("post_msb", {24'd0, m8_data}, 32'hAC);
        chk("post_par", {31'd0, l8_par}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_deser_param.md
# uart_rx_deser_param

Parametrised deserializer for the UART receive path. It sits between the RX sampler/FSM and the byte consumer. It assembles `DATA_WIDTH` sampled bits, LSB- or MSB-first, counts the bits internally, and computes the frame's expected parity bit. The completed word is presented through a valid/ready output register, and an overrun is flagged when a word completes while the previous one is still unconsumed.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; legal range 2..16.
- `LSB_FIRST`, default 1: 1 = first received bit lands in bit 0; 0 = first received bit lands in bit `DATA_WIDTH-1`.

- `clk`  input  1  clock.
- `rst`  input  1  reset, synchronous, active-low.
- `sampled_bit`  input  1  data bit value from the sampler.
- `deser_en`  input  1  one-cycle strobe: accept `sampled_bit` as the next data bit.
- `frame_start`  input  1  one-cycle strobe: a start bit was detected; begin a new word.
- `par_typ`  input  1  0 = even parity, 1 = odd parity; sampled at word completion.
- `out_data`  output  `DATA_WIDTH`  completed word.
- `out_valid`  output  1  `out_data`/`par_bit` hold an unconsumed word.
- `out_ready`  input  1  consumer accepts the word when high with `out_valid`.
- `par_bit`  output  1  expected parity bit for `out_data`.
- `overrun`  output  1  one-cycle pulse: a completed word was dropped.
- `busy`  output  1  high while a word is being assembled.

## Operation
- FSM states: IDLE and SHIFT.
  - IDLE → SHIFT on `frame_start`.
  - SHIFT → IDLE on the edge that accepts bit `DATA_WIDTH`.
  - `frame_start` in SHIFT restarts assembly in place: bit counter := 0, shift register := 0.
- Bit counter width is `$clog2(DATA_WIDTH+1)`.
  - Cleared on `frame_start`.
  - Increments on each `deser_en` accepted in SHIFT.
  - Never wraps; completion returns to IDLE first.
- Shift behaviour in SHIFT, on `deser_en`:
  - `LSB_FIRST`=1: shreg := {sampled_bit, shreg[W-1:1]}.
  - `LSB_FIRST`=0: shreg := {shreg[W-2:0], sampled_bit}.
- `deser_en` in IDLE is ignored.
- `frame_start` and `deser_en` in the same cycle: `frame_start` wins and the bit is discarded.
- Completion: the cycle where `deser_en` is accepted with counter = W-1.
  - The assembled word includes the current bit.
  - Word := shifted value; parity := (^word) XOR `par_typ`.
- Output register load rules at completion:
  - If `out_valid`=0, or `out_valid`=1 and `out_ready`=1: load `out_data`/`par_bit`; `out_valid` := 1.
  - If `out_valid`=1 and `out_ready`=0: keep the old word, drop the new one, pulse `overrun` for one cycle.
- Consumption: `out_valid` and `out_ready` both high with no completion in the same cycle clears `out_valid` on the next edge. `out_data` retains its value.
- `busy` = (state == SHIFT), registered.

## Timing
- Reset (`rst`=0 at a `clk` edge):
  - `out_data`=0, `out_valid`=0, `par_bit`=0, `overrun`=0, `busy`=0.
  - State IDLE; counter and shift register 0.
  - Reset mid-frame aborts the frame silently; no partial word is emitted.
- `busy` rises on the edge after `frame_start` and falls on the edge that accepts the last bit.
- Latency: `out_valid`/`out_data`/`par_bit` update on the same edge that accepts the last bit. They are visible in the following cycle.
- `overrun` is high for exactly the cycle after the dropping edge.
- Output stability: `out_data` and `par_bit` are stable while `out_valid`=1 and not yet handshaken.
- Throughput: `frame_start` may arrive in the cycle immediately after completion. Back-to-back words with `out_ready` tied high never overrun.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- W=8, `LSB_FIRST`=1, `par_typ`=0, bits 1,1,0,0,0,0,0,0 with `out_ready`=1 → `out_data`=8'h03, `par_bit`=0, `out_valid` high for 1 cycle. Repeat with `par_typ`=1 → `par_bit`=1.
- W=8, `LSB_FIRST`=0, same bits → `out_data`=8'hC0. W=5, `LSB_FIRST`=1, bits 1,0,1,1,0 → `out_data`=5'h0D, `par_bit`=1 (even parity, three ones).
- Two consecutive frames (8'h03, then bits 1 ×8) with `out_ready`=0 → `out_data` stays 8'h03, `overrun` pulses once. Then `out_ready`=1 → `out_valid` drops the next cycle.
- Completion in the same cycle as `out_valid`&&`out_ready` → new word loaded, `out_valid` stays 1, `overrun`=0.
- 3 bits, then `frame_start` coinciding with `deser_en`, then 8 bits 0,0,0,0,1,1,1,1 → `out_data`=8'hF0 (LSB_FIRST); the earlier bits and the coincident bit are discarded.
- After 4 bits, `rst`=0 for 1 cycle → all outputs 0, `busy`=0. `deser_en` pulses in IDLE → no change. A subsequent full frame is captured correctly.
